// File: rtl/nes_video_source_if.sv
// rtl/nes_video_source_if.sv - control and video/audio output bundle for nes_video_source
// Ports (master = generator side):
//   in : ce, run, pattern[1:0], solid_color[5:0], render_en, nmi_en, tone_en, tone_half[11:0]
//   out: color[5:0], cycle[8:0], scanline[8:0], sample[15:0], vblank, nmi, frame_odd, frame_cnt[15:0]
interface nes_video_source_if;
  logic        ce;
  logic        run;
  logic [1:0]  pattern;
  logic [5:0]  solid_color;
  logic        render_en;
  logic        nmi_en;
  logic        tone_en;
  logic [11:0] tone_half;
  logic [5:0]  color;
  logic [8:0]  cycle;
  logic [8:0]  scanline;
  logic [15:0] sample;
  logic        vblank;
  logic        nmi;
  logic        frame_odd;
  logic [15:0] frame_cnt;

  modport master (
    input  ce, run, pattern, solid_color, render_en, nmi_en, tone_en, tone_half,
    output color, cycle, scanline, sample, vblank, nmi, frame_odd, frame_cnt
  );

  modport slave (
    output ce, run, pattern, solid_color, render_en, nmi_en, tone_en, tone_half,
    input  color, cycle, scanline, sample, vblank, nmi, frame_odd, frame_cnt
  );
endinterface

// File: rtl/nes_video_source.sv
// rtl/nes_video_source.sv - NES-timed test pattern, vblank/nmi and square-tone generator
// Ports:
//   clk   : NES clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : nes_video_source_if.master (controls in, dot position/color/audio/status out)
module nes_video_source (
  input  logic                 clk,
  input  logic                 reset,
  nes_video_source_if.master   bus
);

  logic [8:0]  cycle_q, scanline_q;
  logic [5:0]  color_q;
  logic        vblank_q, nmi_q, frame_odd_q;
  logic [15:0] frame_cnt_q;
  logic [1:0]  pattern_q;
  logic [11:0] tone_cnt_q;
  logic        phase_q;
  logic [15:0] sample_q;

  logic [8:0]  cycle_n, scanline_n;
  logic        wrap;
  logic        frame_odd_n;
  logic [15:0] frame_cnt_n;
  logic [1:0]  pattern_n;
  logic [5:0]  color_n;
  logic        adv;
  logic        skip;
  logic        vbl_set, vbl_clr;
  logic [11:0] tone_limit;
  logic [11:0] tone_cnt_n;
  logic        phase_n;

  assign adv = bus.ce & bus.run;

  // Odd frames with rendering enabled drop the last dot of the pre-render line.
  assign skip = bus.render_en && frame_odd_q && (scanline_q == 9'd261) && (cycle_q == 9'd339);

  always_comb begin
    cycle_n    = cycle_q + 9'd1;
    scanline_n = scanline_q;
    wrap       = 1'b0;
    if (skip) begin
      cycle_n    = 9'd0;
      scanline_n = 9'd0;
      wrap       = 1'b1;
    end else if (cycle_q == 9'd340) begin
      cycle_n = 9'd0;
      if (scanline_q == 9'd261) begin
        scanline_n = 9'd0;
        wrap       = 1'b1;
      end else begin
        scanline_n = scanline_q + 9'd1;
      end
    end
  end

  assign frame_odd_n = wrap ? ~frame_odd_q : frame_odd_q;
  assign frame_cnt_n = wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
  assign pattern_n   = wrap ? bus.pattern : pattern_q;

  // Color is derived from the post-advance position so it lines up with cycle/scanline.
  always_comb begin
    color_n = 6'h0F;
    if (scanline_n < 9'd240 && cycle_n < 9'd256) begin
      case (pattern_n)
        2'd0: color_n = cycle_n[7:2];
        2'd1: color_n = (cycle_n[3] ^ scanline_n[3]) ? 6'h30 : 6'h0F;
        2'd2: color_n = bus.solid_color;
        default: color_n = cycle_n[7:2] + frame_cnt_n[5:0];
      endcase
    end
  end

  assign vbl_set = (scanline_n == 9'd241) && (cycle_n == 9'd1);
  assign vbl_clr = (scanline_n == 9'd261) && (cycle_n == 9'd1);

  // A half-period of 0 behaves like 1 so the tone still toggles every dot.
  assign tone_limit = (bus.tone_half == 12'd0) ? 12'd0 : bus.tone_half - 12'd1;

  always_comb begin
    tone_cnt_n = tone_cnt_q + 12'd1;
    phase_n    = phase_q;
    if (!bus.tone_en) begin
      tone_cnt_n = 12'd0;
      phase_n    = 1'b0;
    end else if (tone_cnt_q >= tone_limit) begin
      // >= rather than == so a shrunk half-period wraps immediately.
      tone_cnt_n = 12'd0;
      phase_n    = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q     <= 9'd0;
      scanline_q  <= 9'd0;
      color_q     <= 6'h0F;
      vblank_q    <= 1'b0;
      nmi_q       <= 1'b0;
      frame_odd_q <= 1'b0;
      frame_cnt_q <= 16'd0;
      pattern_q   <= 2'd0;
      tone_cnt_q  <= 12'd0;
      phase_q     <= 1'b0;
      sample_q    <= 16'd0;
    end else if (adv) begin
      cycle_q     <= cycle_n;
      scanline_q  <= scanline_n;
      color_q     <= color_n;
      frame_odd_q <= frame_odd_n;
      frame_cnt_q <= frame_cnt_n;
      pattern_q   <= pattern_n;
      if (vbl_set) begin
        vblank_q <= 1'b1;
      end else if (vbl_clr) begin
        vblank_q <= 1'b0;
      end
      nmi_q      <= vbl_set & bus.nmi_en;
      tone_cnt_q <= tone_cnt_n;
      phase_q    <= phase_n;
      if (!bus.tone_en) begin
        sample_q <= 16'd0;
      end else begin
        sample_q <= phase_n ? 16'hF000 : 16'h1000;
      end
    end else begin
      // nmi is a single-clk pulse; it never persists through a hold.
      nmi_q <= 1'b0;
    end
  end

  assign bus.cycle     = cycle_q;
  assign bus.scanline  = scanline_q;
  assign bus.color     = color_q;
  assign bus.vblank    = vblank_q;
  assign bus.nmi       = nmi_q;
  assign bus.frame_odd = frame_odd_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.sample    = sample_q;

endmodule

// File: tb/tb_nes_video_source.sv
// tb/tb_nes_video_source.sv - directed self-checking bench for nes_video_source
module tb_nes_video_source;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   adv;
  int   frame1_start;

  nes_video_source_if vif ();

  nes_video_source dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk; sample outputs on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (vif.ce && vif.run) adv++;
      @(negedge clk);
    end
  endtask

  task automatic goto(input int sl, input int cy);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!(vif.scanline == sl[8:0] && vif.cycle == cy[8:0]) && n < 100000);
    chk("goto_pos", {vif.scanline, vif.cycle}, {sl[8:0], cy[8:0]});
  endtask

  initial begin
    checks = 0; failures = 0; adv = 0; frame1_start = 0;
    reset = 1'b1;
    vif.ce = 1'b1; vif.run = 1'b1; vif.pattern = 2'd0; vif.solid_color = 6'h21;
    vif.render_en = 1'b0; vif.nmi_en = 1'b0; vif.tone_en = 1'b0; vif.tone_half = 12'd4;
    #3;
    chk("rst_cycle", vif.cycle, 0);
    chk("rst_scanline", vif.scanline, 0);
    chk("rst_color", vif.color, 6'h0F);
    chk("rst_vblank", vif.vblank, 0);
    chk("rst_nmi", vif.nmi, 0);
    chk("rst_frame_odd", vif.frame_odd, 0);
    chk("rst_frame_cnt", vif.frame_cnt, 0);
    chk("rst_sample", vif.sample, 0);

    @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("first_cycle", vif.cycle, 1);
    chk("first_scanline", vif.scanline, 0);
    chk("first_color", vif.color, 0);
    step(11);
    chk("bars_c12", vif.color, 3);

    vif.ce = 1'b0;
    step(5);
    chk("ce_hold_cycle", vif.cycle, 12);
    vif.ce = 1'b1;

    // Tone: half=4 toggles every 4 advances.
    vif.tone_en = 1'b1;
    step(1);
    chk("tone_ph0", vif.sample, 16'h1000);
    step(3);
    chk("tone_ph1", vif.sample, 16'hF000);
    step(3);
    chk("tone_ph1_hold", vif.sample, 16'hF000);
    step(1);
    chk("tone_ph0_again", vif.sample, 16'h1000);
    vif.tone_half = 12'd0;
    step(1);
    chk("tone_h0_a", vif.sample, 16'hF000);
    step(1);
    chk("tone_h0_b", vif.sample, 16'h1000);
    vif.tone_half = 12'd4;
    step(3);
    chk("tone_cnt3", vif.sample, 16'h1000);
    vif.tone_half = 12'd2;
    step(1);
    chk("tone_shrink_wrap", vif.sample, 16'hF000);
    vif.tone_en = 1'b0;
    step(1);
    chk("tone_off", vif.sample, 16'h0000);

    // Pattern change mid-frame must not take effect until the frame wraps.
    goto(100, 0);
    vif.pattern = 2'd1;
    goto(100, 8);
    chk("pat_latched_c8", vif.color, 2);

    vif.nmi_en = 1'b1;
    goto(241, 0);
    chk("pre_vbl", vif.vblank, 0);
    step(1);
    chk("vbl_set_pos", {vif.scanline, vif.cycle}, {9'd241, 9'd1});
    chk("vbl_set", vif.vblank, 1);
    chk("nmi_pulse", vif.nmi, 1);
    step(1);
    chk("nmi_gone", vif.nmi, 0);
    chk("vbl_held", vif.vblank, 1);
    goto(261, 0);
    step(1);
    chk("vbl_clr", vif.vblank, 0);

    goto(0, 0);
    chk("frame0_len", adv, 89342);
    chk("frame0_cnt", vif.frame_cnt, 1);
    chk("frame0_odd", vif.frame_odd, 1);
    chk("chk_0_0", vif.color, 6'h0F);
    frame1_start = adv;
    step(8);
    chk("chk_0_8", vif.color, 6'h30);
    goto(0, 256);
    chk("chk_0_256", vif.color, 6'h0F);

    // Odd frame with rendering: last dot of line 261 skipped, no nmi.
    vif.render_en = 1'b1;
    vif.nmi_en = 1'b0;
    vif.pattern = 2'd3;
    goto(241, 1);
    chk("no_nmi", vif.nmi, 0);
    chk("vbl_f1", vif.vblank, 1);
    goto(261, 339);
    step(1);
    chk("skip_pos", {vif.scanline, vif.cycle}, {9'd0, 9'd0});
    chk("frame1_len", adv - frame1_start, 89341);
    chk("frame1_cnt", vif.frame_cnt, 2);
    chk("frame1_odd", vif.frame_odd, 0);

    goto(10, 200);
    chk("scroll_color", vif.color, 6'h34);
    vif.run = 1'b0;
    step(50);
    chk("run_hold_pos", {vif.scanline, vif.cycle}, {9'd10, 9'd200});
    chk("run_hold_color", vif.color, 6'h34);
    chk("run_hold_nmi", vif.nmi, 0);

    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cycle", vif.cycle, 0);
    chk("mid_rst_scanline", vif.scanline, 0);
    chk("mid_rst_color", vif.color, 6'h0F);
    chk("mid_rst_frame_cnt", vif.frame_cnt, 0);
    chk("mid_rst_frame_odd", vif.frame_odd, 0);
    chk("mid_rst_vblank", vif.vblank, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nes_video_source.md
NES_VIDEO_SOURCE -- requirements
Module: nes_video_source

Interface
REQ-001 clk  in  1  NES clock; all logic on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; all state to reset values immediately.
REQ-003 ce  in  1  PPU dot enable; one dot advances per clk with ce=1.
REQ-004 run  in  1  1 = generator advances; 0 = all counters and outputs hold.
REQ-005 pattern  in  2  test pattern select: 0 bars, 1 checker, 2 solid, 3 scrolling bars.
REQ-006 solid_color  in  6  palette index for pattern 2.
REQ-007 render_en  in  1  enables odd-frame dot skip.
REQ-008 nmi_en  in  1  enables nmi pulse.
REQ-009 tone_en  in  1  enables square-wave audio.
REQ-010 tone_half  in  12  tone half-period in dots.
REQ-011 color  out  6  palette index for the current dot.
REQ-012 cycle  out  9  dot within scanline, 0-340.
REQ-013 scanline  out  9  scanline, 0-261.
REQ-014 sample  out  16  signed audio sample.
REQ-015 vblank  out  1  vertical-blank flag.
REQ-016 nmi  out  1  one-clk pulse at vblank set.
REQ-017 frame_odd  out  1  parity of the current frame.
REQ-018 frame_cnt  out  16  completed-frame count; wraps.

Function
REQ-019 Advance condition: the generator SHALL advance only on clk edges with ce=1 and run=1; otherwise every register holds.
- Per advance: cycle increments; at 340 -> 0 and scanline increments.
- At scanline 261, cycle 340 -> scanline 0, cycle 0.
REQ-020 Odd-frame skip: if render_en=1 and frame_odd=1 at scanline 261 cycle 339, the next advance SHALL go to scanline 0 cycle 0; that frame is 89341 dots, otherwise 89342.
REQ-021 Frame wrap (261 -> 0): frame_odd SHALL toggle, frame_cnt SHALL increment mod 2^16, and pattern SHALL be latched into pattern_q; pattern_q is the only pattern used for color.
REQ-022 Output alignment: color, cycle and scanline SHALL be registered and update on the same edge; color SHALL be computed from the new cycle and scanline values (zero relative latency).
REQ-023 Visible region is scanline<240 and cycle<256; outside it color SHALL be 6'h0F.
REQ-024 Pattern colors in the visible region SHALL be:
- 0: cycle[7:2].
- 1: 6'h30 if cycle[3]^scanline[3], else 6'h0F.
- 2: solid_color.
- 3: (cycle[7:2] + frame_cnt[5:0]) mod 64.
REQ-025 vblank SHALL be set on the advance into scanline 241 cycle 1 and cleared on the advance into scanline 261 cycle 1.
REQ-026 nmi SHALL be 1 for exactly the single clk of the vblank set edge when nmi_en=1, and 0 on every other clk including hold cycles.
REQ-027 Tone: a 12-bit dot counter SHALL count advances while tone_en=1.
- On reaching max(tone_half,1)-1 it SHALL reset to 0 and toggle the phase.
- sample SHALL be 16'h1000 for phase 0 and 16'hF000 for phase 1.
REQ-028 Tone disable: when tone_en=0, sample, the tone counter and the phase SHALL be 0 on the next clk; the tone path SHALL be gated by run/ce like the counters.
REQ-029 If tone_half changes mid-period and the counter is already at or above the new limit-1, the counter SHALL wrap at the next advance.
REQ-030 run deasserted mid-frame SHALL freeze the position exactly, and the generator SHALL resume from the same dot.

Reset
REQ-031 On reset, outputs SHALL take: cycle=0, scanline=0, color=6'h0F, vblank=0, nmi=0, frame_odd=0, frame_cnt=0, sample=0.
REQ-032 On reset, internal state SHALL take: pattern_q=0, tone counter=0, phase=0.
REQ-033 On reset release, the first advance SHALL produce cycle=1, scanline=0, color per pattern_q=0 (cycle[7:2]=0).

Verification
REQ-034 Settings run=1, ce=1, render_en=0, one full frame -> wrap after 89342 advances; frame_cnt=1; frame_odd=1.
REQ-035 Settings render_en=1, two frames -> frame 0 takes 89342 dots and frame 1 takes 89341; scanline 261 goes from cycle 339 directly to scanline 0 cycle 0.
REQ-036 Settings nmi_en=1, reaching scanline 241 cycle 1 -> vblank=1 and nmi=1 for one clk; at scanline 261 cycle 1 -> vblank=0; with nmi_en=0 no nmi pulse.
REQ-037 Pattern input changed from 0 to 1 at scanline 100 -> color unchanged until frame wrap. Next frame at (0,8) -> 6'h30; at (0,0) -> 6'h0F; at (0,256) -> 6'h0F.
REQ-038 Settings tone_en=1, tone_half=4 -> sample toggles every 4 advances (h1000, hF000). With tone_half=0 it toggles every advance. Setting tone_en=0 -> sample=0 on the next clk.
REQ-039 run=0 for 50 clks at scanline 10 cycle 200, then reset asserted mid-frame -> no change while run=0; on reset all outputs immediately at REQ-031 values.
